// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver (sync, glitch filter, 11-bit
//            deframer with timeout) feeding a FWFT valid/ready FIFO.
//            Optional E0/F0 prefix folding when PS2_PREFIX_DECODE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     PS2_CLK,
    input  logic                     PS2_DAT,
    output logic [9:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     err_parity,
    output logic                     err_timeout,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_FW = $clog2(FILTER_LEN + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_filt_clk;
    logic [c_FW-1:0]        r_filt_cnt;
    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_par_bit;
    logic [c_TW-1:0]        r_to_cnt;
    logic                   r_err_parity, r_err_timeout, r_overflow;
    logic [9:0]             r_mem [DEPTH];
    logic [c_AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]          r_count;

    logic       w_clk_s, w_dat_s, w_filt_flip, w_fall;
    logic       w_stop_edge, w_frame_ok, w_good, w_bad, w_timeout;
    logic       w_push, w_pop, w_full, w_wr, w_ovf_set;
    logic [9:0] w_push_data;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DAT};
        end
    end

    // Counter tracks how many consecutive samples disagree with the filtered level.
    assign w_filt_flip = (w_clk_s != r_filt_clk) && (r_filt_cnt == c_FILT_LAST);
    assign w_fall      = w_filt_flip && r_filt_clk;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt_clk <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_timeout   = (r_state != S_IDLE) && !w_fall && (r_to_cnt == c_TO_LAST);
    assign w_stop_edge = (r_state == S_STOP) && w_fall;
    assign w_frame_ok  = (^{r_shift, r_par_bit}) && w_dat_s;
    assign w_good      = w_stop_edge && w_frame_ok;
    assign w_bad       = w_stop_edge && !w_frame_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && !w_dat_s)            w_state_nxt = S_DATA;
            S_DATA:   if (w_fall && (r_bit_cnt == 3'd7)) w_state_nxt = S_PARITY;
            S_PARITY: if (w_fall)                        w_state_nxt = S_STOP;
            S_STOP:   if (w_fall)                        w_state_nxt = S_IDLE;
            default:                                     w_state_nxt = S_IDLE;
        endcase
        if (w_timeout)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_par_bit     <= 1'b0;
            r_to_cnt      <= '0;
            r_err_parity  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_err_parity  <= w_bad;
            r_err_timeout <= w_timeout;
            if (w_fall || (r_state == S_IDLE))
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
            if (r_state == S_IDLE)
                r_bit_cnt <= '0;
            if ((r_state == S_DATA) && w_fall) begin
                r_shift   <= {w_dat_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if ((r_state == S_PARITY) && w_fall)
                r_par_bit <= w_dat_s;
        end
    end

`ifdef PS2_PREFIX_DECODE_EN
    logic r_ext_pending, r_brk_pending;
    logic w_is_prefix;

    assign w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0);
    assign w_push      = w_good && !w_is_prefix;
    assign w_push_data = {r_brk_pending, r_ext_pending, r_shift};

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_ext_pending <= 1'b0;
            r_brk_pending <= 1'b0;
        end else if (w_bad || w_timeout) begin
            r_ext_pending <= 1'b0;
            r_brk_pending <= 1'b0;
        end else if (w_good) begin
            if (r_shift == 8'hE0) begin
                r_ext_pending <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_brk_pending <= 1'b1;
            end else begin
                r_ext_pending <= 1'b0;
                r_brk_pending <= 1'b0;
            end
        end
    end
`else
    assign w_push      = w_good;
    assign w_push_data = {2'b00, r_shift};
`endif

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign w_full    = (r_count == c_DEPTH);
    assign w_pop     = rx_valid && rx_ready;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge CLOCK_50) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop)
                r_count <= r_count - 1'b1;
            if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

    assign rx_valid    = (r_count != '0);
    assign rx_data     = rx_valid ? r_mem[r_rd_ptr] : 10'd0;
    assign fifo_count  = r_count;
    assign busy        = (r_state != S_IDLE);
    assign err_parity  = r_err_parity;
    assign err_timeout = r_err_timeout;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Directed, table-driven self-checking bench for ps2_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 10000;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [3:0] fifo_count;
    logic       busy, err_parity, err_timeout, overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int n_perr = 0;
    int n_to   = 0;

    ps2_rx_fifo #(
        .DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_count(fifo_count), .busy(busy), .err_parity(err_parity),
        .err_timeout(err_timeout), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (err_parity)  n_perr++;
        if (err_timeout) n_to++;
    end

    typedef struct {
        logic [7:0] b;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_valid;
        logic [9:0] exp_data;
        int         exp_perr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic ps2_bit(input logic d);
        PS2_DAT = d;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        wait_cyc(20);
        PS2_CLK = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_head(input logic [7:0] b, input logic par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
    endtask

    // Stop bit; optionally pulses rx_ready on one chosen cycle of the low phase
    // and reports the first cycle at which rx_valid was seen.
    task automatic send_stop(input logic d, input int pop_at, output int lat);
        lat = 0;
        PS2_DAT = d;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLOCK_50);
            if (lat == 0 && rx_valid) lat = i;
            if (pop_at > 0) rx_ready = (i == pop_at);
        end
        rx_ready = 1'b0;
        PS2_CLK = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        int lat;
        send_head(b, bad_par ? ^b : ~^b);
        send_stop(!bad_stop, 0, lat);
    endtask

    task automatic pop_expect(input string name, input logic [9:0] exp);
        chk({name, "_valid"}, rx_valid, 1'b1);
        chk({name, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && rx_valid; i++) begin
            rx_ready = 1'b1;
            wait_cyc(1);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        int lat_meas, lat_dummy, p0, t0, waited;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 0};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b1, 10'h05A, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h000, 0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 10'h0FF, 0};
        vecs[5] = '{8'hA5, 1'b0, 1'b1, 1'b0, 10'h000, 1};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 10'h080, 0};
        vecs[7] = '{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000, 1};

        // Reset state
        wait_cyc(3);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rx_data, 10'd0);
        chk("rst_count", fifo_count, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_errs", {err_parity, err_timeout}, 2'b00);
        reset = 1'b1;
        wait_cyc(5);

        // Single frame 0x1C with rx_ready low; also measures push latency
        send_head(8'h1C, 1'b0);
        send_stop(1'b1, 0, lat_meas);
        chk("lat_in_range", (lat_meas >= 2 && lat_meas <= 15), 1'b1);
        chk("single_valid", rx_valid, 1'b1);
        chk("single_data", rx_data, 10'h01C);
        chk("single_count", fifo_count, 4'd1);
        chk("single_perr", n_perr, 0);
        chk("single_to", n_to, 0);
        drain();

        // Table of single frames
        for (int v = 0; v < 8; v++) begin
            p0 = n_perr;
            send_frame(vecs[v].b, vecs[v].bad_par, vecs[v].bad_stop);
            wait_cyc(3);
            chk($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid)
                chk($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
            chk($sformatf("vec%0d_count", v), fifo_count, vecs[v].exp_valid ? 4'd1 : 4'd0);
            chk($sformatf("vec%0d_perr", v), n_perr - p0, vecs[v].exp_perr);
            chk($sformatf("vec%0d_busy", v), busy, 1'b0);
            drain();
        end

        // Overflow: 9 frames into an 8-deep FIFO
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b0);
        chk("ovf_count", fifo_count, 4'd8);
        chk("ovf_set", overflow, 1'b1);
        for (int k = 1; k <= 8; k++) pop_expect($sformatf("ovf_pop%0d", k), 10'(k));
        chk("ovf_empty", fifo_count, 4'd0);
        chk("ovf_sticky", overflow, 1'b1);
        clr_overflow = 1'b1;
        wait_cyc(1);
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // Timeout after start bit + 4 data bits
        t0 = n_to;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        chk("to_busy_mid", busy, 1'b1);
        waited = 0;
        while (n_to == t0 && waited < TIMEOUT + 200) begin
            wait_cyc(1);
            waited++;
        end
        chk("to_pulsed", n_to - t0, 1);
        chk("to_not_early", waited > TIMEOUT - 100, 1'b1);
        wait_cyc(2);
        chk("to_busy_after", busy, 1'b0);
        chk("to_no_push", fifo_count, 4'd0);
        send_frame(8'h5A, 1'b0, 1'b0);
        pop_expect("to_next", 10'h05A);

        // Full FIFO, pop coincident with push of 0x33
        for (int k = 0; k < 8; k++) send_frame(8'h10 + 8'(k), 1'b0, 1'b0);
        chk("full_count", fifo_count, 4'd8);
        send_head(8'h33, ~^8'h33);
        send_stop(1'b1, lat_meas - 1, lat_dummy);
        wait_cyc(3);
        chk("pp_count", fifo_count, 4'd8);
        chk("pp_no_ovf", overflow, 1'b0);
        for (int k = 1; k < 8; k++) pop_expect($sformatf("pp_pop%0d", k), 10'h010 + 10'(k));
        pop_expect("pp_tail", 10'h033);
        chk("pp_empty", fifo_count, 4'd0);

        // Glitches shorter than the filter length must not start a frame
        for (int g = 1; g <= 3; g += 2) begin
            PS2_DAT = 1'b0;
            wait_cyc(2);
            PS2_CLK = 1'b0;
            wait_cyc(g);
            PS2_CLK = 1'b1;
            wait_cyc(15);
            chk($sformatf("glitch%0d_busy", g), busy, 1'b0);
        end
        PS2_DAT = 1'b1;
        wait_cyc(5);
        send_frame(8'h29, 1'b0, 1'b0);
        pop_expect("glitch_after", 10'h029);

        // Prefix bytes
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
        chk("pfx_count", fifo_count, 4'd1);
        pop_expect("pfx_folded", 10'h374);
`else
        chk("pfx_count", fifo_count, 4'd3);
        pop_expect("pfx_e0", 10'h0E0);
        pop_expect("pfx_f0", 10'h0F0);
        pop_expect("pfx_74", 10'h074);
`endif

        // Reset asserted mid-frame with data buffered and overflow set
        for (int k = 0; k < 9; k++) send_frame(8'h40 + 8'(k), 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        chk("mid_busy", busy, 1'b1);
        chk("mid_ovf", overflow, 1'b1);
        reset = 1'b0;
        #1;
        chk("mrst_valid", rx_valid, 1'b0);
        chk("mrst_data", rx_data, 10'd0);
        chk("mrst_count", fifo_count, 4'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ovf", overflow, 1'b0);
        chk("mrst_errs", {err_parity, err_timeout}, 2'b00);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(5);
        send_frame(8'h66, 1'b0, 1'b0);
        pop_expect("mrst_after", 10'h066);
        chk("mrst_empty", fifo_count, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
